// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester line-burst memory arbiter.
// The slave side is the arbiter; the master side is the environment
// (the two requesters plus the single-port memory's read-data return).
interface mem_arbiter_if #(
   parameter int ADDR_LEN      = 11,
   parameter int LINE_ADDR_LEN = 3
);
   // requester side
   logic                     req0, req1;
   logic                     we0, we1;
   logic [ADDR_LEN-1:0]      addr0, addr1;
   logic [31:0]              wdata0, wdata1;
   logic                     gnt0, gnt1;
   logic                     rvalid0, rvalid1;
   logic                     done0, done1;
   logic [LINE_ADDR_LEN-1:0] beat_idx;
   logic [31:0]              rdata;
   // memory side
   logic [ADDR_LEN-1:0]      mem_addr;
   logic                     mem_wr_req;
   logic [31:0]              mem_wr_data;
   logic [31:0]              mem_rd_data;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd_data,
      output gnt0, gnt1, rvalid0, rvalid1, done0, done1, beat_idx, rdata,
             mem_addr, mem_wr_req, mem_wr_data
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd_data,
      input  gnt0, gnt1, rvalid0, rvalid1, done0, done1, beat_idx, rdata,
             mem_addr, mem_wr_req, mem_wr_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that moves whole lines (N = 2^LINE_ADDR_LEN
// words) to/from a single-port memory with one-cycle registered read latency.
// Writes take N cycles; reads take N+1 because the first word arrives one
// cycle after its address. Outputs decode from state, so an async reset
// drops them all in the same cycle.
module mem_arbiter #(
   parameter int ADDR_LEN      = 11,
   parameter int LINE_ADDR_LEN = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   localparam int N = 1 << LINE_ADDR_LEN;
   localparam logic [LINE_ADDR_LEN:0] CNT_WR_LAST = (LINE_ADDR_LEN+1)'(N - 1);
   localparam logic [LINE_ADDR_LEN:0] CNT_RD_LAST = (LINE_ADDR_LEN+1)'(N);
   localparam logic [LINE_ADDR_LEN:0] CNT_ONE     = (LINE_ADDR_LEN+1)'(1);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t                   state, state_nxt;
   logic [LINE_ADDR_LEN:0]   cnt;       // one extra bit so READ can reach N
   logic [ADDR_LEN-1:0]      base;      // line base, low bits zero
   logic                     we_lat;
   logic                     owner;     // requester holding the current burst
   logic                     rr_ptr;    // requester that wins the next tie

   logic [1:0]               req_v;
   logic                     win;
   logic                     we_sel;
   logic [ADDR_LEN-1:0]      addr_sel;
   logic                     last;
   logic [LINE_ADDR_LEN-1:0] cnt_lo;
   logic [LINE_ADDR_LEN:0]   cnt_m1;
   logic [ADDR_LEN-1:0]      line_addr;
   logic [31:0]              wdata_sel;
   logic [1:0]               gnt_v, rvalid_v, done_v;

   // Arbitration: a lone request wins outright, a tie goes to rr_ptr.
   always_comb begin
      req_v    = {bus.req1, bus.req0};
      win      = (req_v == 2'b11) ? rr_ptr : req_v[1];
      we_sel   = win ? bus.we1   : bus.we0;
      addr_sel = win ? bus.addr1 : bus.addr0;
   end

   // Datapath helpers; the counter's low bits OR into the base so the
   // address can never carry out of the line.
   always_comb begin
      last      = we_lat ? (cnt == CNT_WR_LAST) : (cnt == CNT_RD_LAST);
      cnt_lo    = cnt[LINE_ADDR_LEN-1:0];
      cnt_m1    = cnt - CNT_ONE;
      line_addr = base | {{(ADDR_LEN-LINE_ADDR_LEN){1'b0}}, cnt_lo};
      wdata_sel = owner ? bus.wdata1 : bus.wdata0;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: IDLE launches a burst, bursts return to IDLE on their last beat.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req_v) state_nxt = we_sel ? WRITE : READ;
         WRITE,
         READ:    if (last)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Burst context: latched only in IDLE, so req/we/addr changes mid-burst are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         base   <= '0;
         we_lat <= 1'b0;
         owner  <= 1'b0;
         rr_ptr <= 1'b0;
      end else if (state == IDLE) begin
         cnt <= '0;
         if (|req_v) begin
            base   <= {addr_sel[ADDR_LEN-1:LINE_ADDR_LEN], {LINE_ADDR_LEN{1'b0}}};
            we_lat <= we_sel;
            owner  <= win;
            rr_ptr <= ~win;
         end
      end else begin
         cnt <= last ? '0 : cnt + CNT_ONE;
      end
   end

   // Output decode; everything is zero outside a burst.
   always_comb begin
      gnt_v           = '0;
      rvalid_v        = '0;
      done_v          = '0;
      bus.mem_addr    = '0;
      bus.mem_wr_req  = 1'b0;
      bus.mem_wr_data = '0;
      bus.beat_idx    = '0;
      case (state)
         WRITE: begin
            gnt_v[owner]    = 1'b1;
            bus.mem_addr    = line_addr;
            bus.mem_wr_req  = 1'b1;
            bus.mem_wr_data = wdata_sel;
            bus.beat_idx    = cnt_lo;
            done_v[owner]   = last;
         end
         READ: begin
            gnt_v[owner] = 1'b1;
            if (cnt != CNT_RD_LAST) bus.mem_addr = line_addr;
            if (cnt != '0) begin
               rvalid_v[owner] = 1'b1;
               bus.beat_idx    = cnt_m1[LINE_ADDR_LEN-1:0];
            end
            done_v[owner] = last;
         end
         default: ;
      endcase
   end

   assign bus.gnt0    = gnt_v[0];
   assign bus.gnt1    = gnt_v[1];
   assign bus.rvalid0 = rvalid_v[0];
   assign bus.rvalid1 = rvalid_v[1];
   assign bus.done0   = done_v[0];
   assign bus.done1   = done_v[1];
   assign bus.rdata   = bus.mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: single-port memory model plus a burst-level
// reference (shadow memory, round-robin owner prediction).
module tb_mem_arbiter;
   localparam int AL = 11;
   localparam int LL = 3;
   localparam int N  = 1 << LL;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_LEN(AL), .LINE_ADDR_LEN(LL)) bus ();
   mem_arbiter #(.ADDR_LEN(AL), .LINE_ADDR_LEN(LL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int failed = 0;

   logic [31:0] wb0 = '0, wb1 = '0;
   assign bus.wdata0 = wb0 + 32'(bus.beat_idx);
   assign bus.wdata1 = wb1 + 32'(bus.beat_idx);

   function automatic logic [31:0] pre(int i);
      logic [31:0] l0 [0:7];
      logic [31:0] l1 [0:7];
      l0 = '{32'h0c, 32'ha8, 32'h34, 32'hc7, 32'h94, 32'hc5, 32'h76, 32'h87};
      l1 = '{32'haa, 32'ha7, 32'hda, 32'h92, 32'h6a, 32'h30, 32'h09, 32'ha4};
      if (i < 8)        return l0[i];
      else if (i < 16)  return l1[i-8];
      else if (i == 19) return 32'h16;
      else              return 32'(i) * 32'h9e37 ^ 32'h5a5a0000;
   endfunction

   // single-port memory: registered read, synchronous write, preloaded once
   logic [31:0] mem [0:2047];
   logic        loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 2048; i++) mem[i] <= pre(i);
         loaded <= 1'b1;
      end else if (bus.mem_wr_req) begin
         mem[bus.mem_addr] <= bus.mem_wr_data;
      end
      bus.mem_rd_data <= mem[bus.mem_addr];
   end

   logic [31:0] ref_mem [0:2047];
   bit          ref_last;   // requester granted most recently

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_flags"}, 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                                bus.done0, bus.done1, bus.mem_wr_req}), 32'd0);
      chk({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
      chk({tag, "_wdata"}, bus.mem_wr_data, 32'd0);
      chk({tag, "_beat"},  32'(bus.beat_idx), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; wb0 = '0; wb1 = '0;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      ref_last = 1'b1;
   endtask

   // Follows one burst beat by beat from the negedge after its grant edge.
   // abort_at >= 0 pulls reset in that beat and checks the immediate idle.
   task automatic burst(input bit w, input bit we, input logic [AL-1:0] addr,
                        input logic [31:0] db, input int abort_at);
      int base = int'(addr) & ~(N - 1);
      int len  = we ? N : N + 1;
      logic [5:0] fl, fe;
      ref_last = w;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_idle("abort");
            bus.req0 = 0; bus.req1 = 0;
            return;
         end
         fl = w ? {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.done1, bus.done0}
                : {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.done0, bus.done1};
         fe = {1'b1, 1'b0, (!we && k >= 1), 1'b0, (k == len - 1), 1'b0};
         chk($sformatf("flags_w%0d_k%0d", w, k), 32'(fl), 32'(fe));
         chk("wr_req", 32'(bus.mem_wr_req), 32'(we));
         chk($sformatf("mem_addr_k%0d", k), 32'(bus.mem_addr), (k < N) ? 32'(base + k) : 32'd0);
         if (we) begin
            chk("wbeat", 32'(bus.beat_idx), 32'(k));
            chk("wdata", bus.mem_wr_data, db + 32'(k));
            ref_mem[base + k] = db + 32'(k);
         end else if (k >= 1) begin
            chk("rbeat", 32'(bus.beat_idx), 32'(k - 1));
            chk($sformatf("rdata_%0h", base + k - 1), bus.rdata, ref_mem[base + k - 1]);
         end
         if (k == len - 1) begin
            if (w) bus.req1 = 0; else bus.req0 = 0;
         end
      end
   endtask

   // Raise the given requests in an IDLE cycle and follow every burst they cause.
   task automatic serve(input bit r0, input bit r1, input bit e0, input bit e1,
                        input logic [AL-1:0] a0, input logic [AL-1:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
      bit p0 = r0, p1 = r1, w;
      bus.req0 = r0; bus.req1 = r1; bus.we0 = e0; bus.we1 = e1;
      bus.addr0 = a0; bus.addr1 = a1; wb0 = d0; wb1 = d1;
      while (p0 || p1) begin
         w = (p0 && p1) ? !ref_last : p1;
         burst(w, w ? e1 : e0, w ? a1 : a0, w ? d1 : d0, -1);
         if (w) p1 = 0; else p0 = 0;
         @(negedge clk);
         chk_idle("gap");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit w;
      logic [1:0] r;
      for (int i = 0; i < 2048; i++) ref_mem[i] = pre(i);
      do_reset();

      // line read from 0
      serve(1, 0, 0, 0, 11'd0, 11'd0, 0, 0);

      // simultaneous first requests after reset: 0 wins, then 1
      do_reset();
      serve(1, 1, 0, 0, 11'd0, 11'd8, 0, 0);

      // unaligned address reads the whole line from its base
      serve(1, 0, 0, 0, 11'd5, 11'd0, 0, 0);

      // reset after three write beats to line 16
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 11'd16; wb1 = 32'h200;
      burst(1, 1, 11'd16, 32'h200, 3);
      do_reset();
      for (int i = 0; i < 4; i++)
         chk($sformatf("abort_mem%0d", 16 + i), mem[16 + i], (i < 3) ? 32'h200 + 32'(i) : 32'h16);
      for (int i = 3; i < 8; i++) ref_mem[16 + i] = mem[16 + i];

      // write line 16 from requester 1, read it back through requester 0
      serve(0, 1, 0, 1, 11'd0, 11'd16, 0, 32'h100);
      serve(1, 0, 0, 0, 11'd16, 11'd0, 0, 0);

      // both requesters hold req; each re-requests in the IDLE cycle
      do_reset();
      bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 11'd0; bus.addr1 = 11'd8;
      for (int i = 0; i < 4; i++) begin
         w = !ref_last;
         chk($sformatf("alt_turn%0d", i), 32'(w), 32'(i % 2));
         burst(w, 0, w ? 11'd8 : 11'd0, 0, -1);
         @(negedge clk);
         chk_idle("alt_gap");
         if (i < 3) begin
            if (w) bus.req1 = 1; else bus.req0 = 1;
         end else begin
            bus.req0 = 0; bus.req1 = 0;
         end
      end

      // random mixes of single and paired bursts
      for (int i = 0; i < 24; i++) begin
         r = 2'($urandom_range(1, 3));
         serve(r[0], r[1], 1'($urandom), 1'($urandom),
               11'($urandom), 11'($urandom), $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
